// File: rtl/quant_stream.sv
// Streaming FP32 -> signed OUT_W-bit quantizer: q = clip(round(x * scale_inv) + zero_point).
// Two register stages (unpack/multiply, then shift/round/clip) with valid/ready on both sides.
module quant_stream #(
    parameter int OUT_W      = 8,
    parameter int ROUND_MODE = 0,
    parameter int SYMMETRIC  = 0,
    parameter int SATCNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic [31:0]         scale_inv,
    input  logic [OUT_W-1:0]    zero_point,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat,
    output logic                out_nan,
    input  logic                amax_clr,
    output logic [31:0]         amax,
    output logic [SATCNT_W-1:0] sat_count
);

    localparam int MAG_W = OUT_W + 2;
    localparam int SUM_W = OUT_W + 3;
    localparam int HI_I  = (1 << (OUT_W - 1)) - 1;
    localparam int LO_I  = (SYMMETRIC != 0) ? -HI_I : -HI_I - 1;
    localparam logic signed [SUM_W-1:0] CLIP_HI = SUM_W'(HI_I);
    localparam logic signed [SUM_W-1:0] CLIP_LO = SUM_W'(LO_I);
    // Magnitude cap 2^(OUT_W+1): far enough out that any zero_point still clips.
    localparam logic [MAG_W-1:0] MAG_CAP = {2'b10, {OUT_W{1'b0}}};

    logic adv1, adv2;
    logic v1, v2;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // ---------------- stage 1: unpack and multiply ----------------
    logic              sx, ss;
    logic [7:0]        ex, es;
    logic [22:0]       fx, fs;
    logic              x_zero, s_zero, x_inf, s_inf, x_nan, s_nan;
    logic              nan_c, inf_c, zero_c;
    logic [47:0]       mant_c;
    logic signed [9:0] exp_c;

    assign sx = in_data[31];
    assign ex = in_data[30:23];
    assign fx = in_data[22:0];
    assign ss = scale_inv[31];
    assign es = scale_inv[30:23];
    assign fs = scale_inv[22:0];

    assign x_zero = (ex == 8'h00);
    assign s_zero = (es == 8'h00);
    assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
    assign s_inf  = (es == 8'hFF) && (fs == 23'd0);
    assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
    assign s_nan  = (es == 8'hFF) && (fs != 23'd0);

    assign nan_c  = x_nan || s_nan || (x_inf && s_zero) || (s_inf && x_zero);
    assign inf_c  = (x_inf || s_inf) && !nan_c;
    assign zero_c = (x_zero || s_zero) && !nan_c && !inf_c;

    assign mant_c = 48'({1'b1, fx}) * 48'({1'b1, fs});
    // Product value is mant_c * 2^exp_c; range -298..208 fits 10 bits signed.
    assign exp_c  = $signed({2'b00, ex}) + $signed({2'b00, es}) - 10'sd300;

    logic [47:0]             mant1;
    logic signed [9:0]       exp1;
    logic                    sign1, nan1, inf1, zero1;
    logic signed [OUT_W-1:0] zp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mant1 <= '0;
            exp1  <= '0;
            sign1 <= 1'b0;
            nan1  <= 1'b0;
            inf1  <= 1'b0;
            zero1 <= 1'b0;
            zp1   <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                mant1 <= mant_c;
                exp1  <= exp_c;
                sign1 <= sx ^ ss;
                nan1  <= nan_c;
                inf1  <= inf_c;
                zero1 <= zero_c;
                zp1   <= zero_point;
            end
        end
    end

    // ---------------- stage 2: shift, round, offset, clip ----------------
    logic [9:0]              neg_e;
    logic [5:0]              sh_c;
    logic [95:0]             shifted;
    logic [47:0]             floor_v;
    logic                    rbit, sticky, inc;
    logic [48:0]             rounded;
    logic [MAG_W-1:0]        mag_c;
    logic signed [SUM_W-1:0] val_c, sum_c, clip_c;
    logic                    sat_c;
    logic [OUT_W-1:0]        data_c;

    // Beyond a 50-bit right shift the value is below 0.25, so clamping the shift is exact.
    assign neg_e   = 10'(-exp1);
    assign sh_c    = (neg_e > 10'd50) ? 6'd50 : neg_e[5:0];
    assign shifted = {mant1, 48'd0} >> sh_c;
    assign floor_v = shifted[95:48];
    assign rbit    = shifted[47];
    assign sticky  = |shifted[46:0];
    assign inc     = (ROUND_MODE == 0) && rbit && (sticky || floor_v[0]);
    assign rounded = {1'b0, floor_v} + 49'(inc);

    always_comb begin
        mag_c = '0;
        if (zero1)
            mag_c = '0;
        else if (inf1 || !exp1[9])
            mag_c = MAG_CAP;
        else if (rounded >= 49'(MAG_CAP))
            mag_c = MAG_CAP;
        else
            mag_c = rounded[MAG_W-1:0];
    end

    assign val_c = sign1 ? -$signed({1'b0, mag_c}) : $signed({1'b0, mag_c});
    assign sum_c = val_c + $signed({{3{zp1[OUT_W-1]}}, zp1});

    always_comb begin
        clip_c = sum_c;
        sat_c  = 1'b0;
        if (sum_c > CLIP_HI) begin
            clip_c = CLIP_HI;
            sat_c  = 1'b1;
        end else if (sum_c < CLIP_LO) begin
            clip_c = CLIP_LO;
            sat_c  = 1'b1;
        end
    end

    assign data_c = clip_c[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_nan  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_data <= nan1 ? '0 : data_c;
                out_sat  <= nan1 ? 1'b0 : sat_c;
                out_nan  <= nan1;
            end
        end
    end

    // ---------------- calibration and saturation statistics ----------------
    logic in_is_nan;
    assign in_is_nan = x_nan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amax <= '0;
        end else if (amax_clr) begin
            amax <= '0;
        end else if (in_valid && in_ready && !in_is_nan && (in_data[30:0] > amax[30:0])) begin
            amax <= {1'b0, in_data[30:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (v2 && out_ready && out_sat && (sat_count != {SATCNT_W{1'b1}})) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_quant_stream.sv
// Directed bench for quant_stream: a real-arithmetic reference model fills a scoreboard
// queue on every accepted input; results are popped and compared as they leave the DUT.
module tb_quant_stream;

    localparam int OUT_W      = 8;
    localparam int ROUND_MODE = 0;
    localparam int SYMMETRIC  = 0;
    localparam int SATCNT_W   = 16;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_data;
    logic [31:0]         scale_inv;
    logic [OUT_W-1:0]    zero_point;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                out_sat;
    logic                out_nan;
    logic                amax_clr;
    logic [31:0]         amax;
    logic [SATCNT_W-1:0] sat_count;

    quant_stream #(
        .OUT_W(OUT_W), .ROUND_MODE(ROUND_MODE), .SYMMETRIC(SYMMETRIC), .SATCNT_W(SATCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .scale_inv(scale_inv), .zero_point(zero_point),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_nan(out_nan),
        .amax_clr(amax_clr), .amax(amax), .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             nan;
    } exp_t;

    exp_t             sb[$];
    int               compared   = 0;
    int               mismatched = 0;
    logic [31:0]      m_amax     = '0;
    int               m_sat      = 0;
    logic             last_accept = 1'b0;
    logic             saw_stall   = 1'b0;
    logic             held_valid  = 1'b0;
    logic [OUT_W-1:0] held_data;
    logic             held_sat, held_nan;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic real fp2real(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'h00) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] s,
                                   input logic [OUT_W-1:0] zp);
        exp_t r;
        logic xn, sn, xi, si, xz, sz;
        real  p, a, f, d;
        int   m, v, t, hi, lo;
        r.data = '0; r.sat = 1'b0; r.nan = 1'b0;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        sn = (s[30:23] == 8'hFF) && (s[22:0] != 0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        si = (s[30:23] == 8'hFF) && (s[22:0] == 0);
        xz = (x[30:23] == 8'h00);
        sz = (s[30:23] == 8'h00);
        if (xn || sn || (xi && sz) || (si && xz)) begin
            r.nan = 1'b1;
            return r;
        end
        if (xi || si) begin
            m = 1000000;
        end else begin
            p = fp2real(x) * fp2real(s);
            a = (p < 0.0) ? -p : p;
            if (a > 1.0e6) begin
                m = 1000000;
            end else begin
                f = $floor(a);
                d = a - f;
                m = $rtoi(f);
                if (ROUND_MODE == 0 && (d > 0.5 || (d == 0.5 && (m % 2) == 1))) m++;
            end
        end
        v  = (x[31] ^ s[31]) ? -m : m;
        t  = v + int'(signed'(zp));
        hi = (1 << (OUT_W - 1)) - 1;
        lo = (SYMMETRIC != 0) ? -hi : -hi - 1;
        if (t > hi) begin t = hi; r.sat = 1'b1; end
        else if (t < lo) begin t = lo; r.sat = 1'b1; end
        r.data = OUT_W'(t);
        return r;
    endfunction

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (held_valid) begin
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_sat", 32'(out_sat), 32'(held_sat));
            check("hold_nan", 32'(out_nan), 32'(held_nan));
        end
        held_valid = out_valid && !out_ready;
        held_data  = out_data;
        held_sat   = out_sat;
        held_nan   = out_nan;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_sat", 32'(out_sat), 32'(e.sat));
                check("out_nan", 32'(out_nan), 32'(e.nan));
                if (e.sat) m_sat++;
            end
        end
        last_accept = in_valid && in_ready;
        if (last_accept) sb.push_back(model(in_data, scale_inv, zero_point));
        if (amax_clr)
            m_amax = '0;
        else if (last_accept && !(in_data[30:23] == 8'hFF && in_data[22:0] != 0)
                 && in_data[30:0] > m_amax[30:0])
            m_amax = {1'b0, in_data[30:0]};
        if (!in_ready) saw_stall = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x);
        in_data  = x;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_accept) break;
        end
        check("send_accept", 32'(last_accept), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] r;
        r = {1'($urandom_range(0, 1)), 8'(125 + $urandom_range(0, 7)), 23'($urandom)};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; scale_inv = '0;
        zero_point = '0; out_ready = 1'b1; amax_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_out_nan", 32'(out_nan), 32'd0);
        check("rst_amax", amax, 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Rounding at scale 1.0; beat accepted at one edge shows out_valid after the next.
        scale_inv = 32'h3F800000; zero_point = '0;
        send(32'h40200000);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        send(32'h40600000);
        check("lat_valid", 32'(out_valid), 32'd1);
        send(32'hBFC00000);
        drain();
        check("sat_count_none", 32'(sat_count), 32'(m_sat));

        // Saturation both ways
        send(32'h447A0000);
        send(32'hC47A0000);
        drain();
        check("sat_count_two", 32'(sat_count), 32'(m_sat));

        // Scale 0.125 with zero point 3, plus special values
        scale_inv = 32'h3E000000; zero_point = 8'd3;
        send(32'h41A00000);
        send(32'h7FC00000);
        send(32'h00000001);
        send(32'h7F800000);
        send(32'hFF800000);
        scale_inv = 32'h00000000;
        send(32'h7F800000);
        scale_inv = 32'hBF800000; zero_point = 8'hFB;
        send(32'h40200000);
        drain();
        check("sat_count_special", 32'(sat_count), 32'(m_sat));

        // Backpressure: 8 beats, downstream stalls for cycles 3..6
        scale_inv = 32'h3F800000;
        saw_stall = 1'b0;
        sent = 0;
        in_data = rand_x();
        zero_point = OUT_W'(int'($urandom_range(0, 40)) - 20);
        in_valid = 1'b1;
        for (int i = 0; i < 40 && sent < 8; i++) begin
            out_ready = (i < 3 || i > 6);
            step();
            if (last_accept) begin
                sent++;
                in_data = rand_x();
                zero_point = OUT_W'(int'($urandom_range(0, 40)) - 20);
            end
        end
        in_valid = 1'b0;
        check("bp_sent", 32'(sent), 32'd8);
        check("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
        drain();
        check("sat_count_bp", 32'(sat_count), 32'(m_sat));

        // amax tracking and clear priority
        amax_clr = 1'b1; step(); amax_clr = 1'b0;
        check("amax_cleared", amax, m_amax);
        send(32'hC0400000);
        send(32'h3F800000);
        send(32'h7FC00000);
        send(32'h40000000);
        step();
        check("amax_track", amax, m_amax);
        check("amax_value", amax, 32'h40400000);
        in_data = 32'h40A00000; in_valid = 1'b1; amax_clr = 1'b1;
        step();
        in_valid = 1'b0; amax_clr = 1'b0;
        check("amax_clr_priority", amax, 32'd0);
        send(32'h40A00000);
        check("amax_update", amax, 32'h40A00000);
        drain();

        // Asynchronous reset with beats in flight
        scale_inv = 32'h3F800000; zero_point = '0;
        in_data = 32'h447A0000; in_valid = 1'b1;
        step();
        in_data = 32'h3F800000;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sat_count", 32'(sat_count), 32'd0);
        check("async_rst_amax", amax, 32'd0);
        sb.delete();
        m_amax = '0; m_sat = 0; held_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(32'h40200000);
        check("post_rst_not_yet", 32'(out_valid), 32'd0);
        step();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/quant_stream.md
Name: quant_stream

Overview:
- Pipelined, streaming FP32-to-signed-integer quantizer with valid/ready handshakes on both sides.
- Computes q = clip(round(x * scale_inv) + zero_point) for a parametrised output width, with a selectable rounding mode and a selectable clip range.
- Performs sign-correct rounding and handles special IEEE-754 values.
- Tracks running max |x| for calibration and counts saturations.
- Sits between the FP32 activation producer and the int MAC array input buffers.

Parameters:
- OUT_W, 8, output integer width in bits (4..16).
- ROUND_MODE, 0, 0 = round-half-to-even; 1 = truncate toward zero.
- SYMMETRIC, 0, 0 = clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; 1 = clip to [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1].
- SATCNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  32  FP32 value x
- scale_inv  in  32  FP32 multiplier; sampled together with in_data
- zero_point  in  OUT_W  signed zero point; sampled together with in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed quantized result
- out_sat  out  1  result was clipped (includes ±Inf inputs)
- out_nan  out  1  input or product was NaN; out_data forced to 0
- amax_clr  in  1  synchronous clear of amax
- amax  out  32  FP32 max |x| over accepted non-NaN inputs
- sat_count  out  SATCNT_W  number of saturated results delivered

Behaviour:
- Reset: asynchronous and active-low. While rst_n = 0, all registers clear: out_valid = 0, out_data = 0, out_sat = 0, out_nan = 0, amax = 0, sat_count = 0, both pipeline stage valids = 0. in_ready = 1 after reset. Reset mid-stream discards all in-flight beats.
- Pipeline: two register stages, so latency is exactly 2 cycles from input accept to out_valid with no stall.
  - S1: unpack both operands, 24x24 mantissa multiply, exponent sum E = e_x + e_s - 254 - 46, sign = s_x ^ s_s, special-case flags.
  - S2: shift, round, zero_point add, clip, flags.
- Handshake:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2.
  - in_ready = adv1, combinational and without dependence on in_valid.
  - A beat transfers when valid & ready are both high on a rising clk edge.
  - out_data, out_sat and out_nan hold stable while out_valid = 1 and out_ready = 0.
  - Full throughput is 1 beat/cycle.
- Arithmetic:
  - The exact product P = M * 2^E is never rounded to FP32 first.
  - The integer magnitude is floor(P). With ROUND_MODE = 0, add 1 when the round bit is 1 and (sticky bit | lsb) is 1. The sign is then applied.
  - Pre-clip magnitude saturates at 2^(OUT_W+1) before the zero_point add, so no overflow in an OUT_W+3-bit signed intermediate.
  - After adding zero_point, clip to the SYMMETRIC range. out_sat = 1 iff clipping changed the value.
- Special cases:
  - Exponent 0 on either operand (zero or denormal) is flushed to zero, giving q = zero_point clipped.
  - Inf operand with a nonzero other operand: saturate toward the product sign, out_sat = 1.
  - NaN operand, or Inf x 0: out_data = 0, out_nan = 1, out_sat = 0.
- amax: on each accepted input that is not NaN, if |in_data| (bits [30:0] compared as unsigned) > amax[30:0], then amax <= {1'b0, in_data[30:0]}. Updated the cycle after accept.
  - amax_clr has priority over a same-cycle update: the result is 0.
  - Inf inputs are recorded.
- sat_count increments when an output beat with out_sat = 1 transfers. It sticks at all-ones and does not wrap. It clears only on reset.

Test Plan:
- scale_inv = 0x3F800000 (1.0), zp = 0: inputs 0x40200000 (2.5), 0x40600000 (3.5), 0xBFC00000 (-1.5) -> out_data 2, 4, -2. With ROUND_MODE = 1 -> 2, 3, -1.
- scale_inv = 0x3F800000, zp = 0: input 0x447A0000 (1000.0) -> 127, out_sat = 1, sat_count = 1. Input 0xC47A0000 (-1000.0) -> -128, or -127 when SYMMETRIC = 1.
- scale_inv = 0x3E000000 (0.125), zp = 3: input 0x41A00000 (20.0) -> 20*0.125 = 2.5, rounds to 2, out 5. Input 0x7FC00000 (NaN) -> out 0, out_nan = 1. Input 0x00000001 (denormal) -> out 3.
- Backpressure: stream 8 beats with out_ready low for cycles 3-6 -> no beat lost or duplicated, output order preserved, in_ready low once both stages are full, held outputs stable.
- amax: inputs -3.0, 1.0, NaN, 2.0 -> amax = 0x40400000. Assert amax_clr in the same cycle as a 5.0 update -> amax = 0.
- Reset: assert rst_n = 0 while 2 beats are in flight -> out_valid = 0 immediately (asynchronous), sat_count = 0, amax = 0. After release, the first new beat appears 2 cycles after accept.
